// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and widths for the FFT frame sequencer.
//   TOTAL_STAGE : width of the stage address bus (max log2 frame length)
//   CPLX_WIDTH  : width of one complex sample, {real, imag}
//   cplx_t      : packed complex sample payload
//   state_t     : frame sequencer states (2-bit encoding)
package fft_frame_ctrl_pkg;

  localparam int unsigned TOTAL_STAGE = 10;
  localparam int unsigned REAL_W      = 16;
  localparam int unsigned IMGN_W      = 16;
  localparam int unsigned CPLX_WIDTH  = REAL_W + IMGN_W;

  typedef struct packed {
    logic [REAL_W-1:0] re;
    logic [IMGN_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_frame_ctrl_lat_cnt.sv
// Loadable down-counter tracking a fixed pipeline latency.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_load    : load LAT-1 (first cycle after load counts as one)
//   o_zero_c  : combinational flag, counter is at zero
// Counts down by one per cycle until zero, then holds.
module fft_lat_cnt #(
  parameter int unsigned LAT = 14
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_zero_c
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LAT - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer at the head of the FFT stage pipeline.
// Accepts N = 2**FFT_STG samples per frame over valid/ready, tags each with a
// sequential stage address, then waits PIPE_LAT cycles for the stage chain to
// drain and pulses odone.
//   iclk/irst          : clock, synchronous active-high reset
//   istart             : frame request, honoured only in IDLE
//   idata/ivalid       : input sample and valid
//   oready             : sample accepted this cycle when ivalid is high
//   oaddr/odata/oen    : registered sample, its stage address, and enable
//   obusy              : high in LOAD and DRAIN
//   odone              : one-cycle pulse when the frame has drained
//   oerr               : sticky protocol error, cleared only by irst
// Build option: FFT_FRAME_STALL_EN allows ivalid gaps inside a frame; when
// undefined, a gap after the first accepted sample aborts the frame and sets oerr.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int unsigned FFT_STG  = 7,
  parameter int unsigned PIPE_LAT = 14
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   istart,
  input  logic [CPLX_WIDTH-1:0]  idata,
  input  logic                   ivalid,
  output logic                   oready,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [CPLX_WIDTH-1:0]  odata,
  output logic                   oen,
  output logic                   obusy,
  output logic                   odone,
  output logic                   oerr
);

  localparam int unsigned CNT_W    = FFT_STG;
  localparam int unsigned LAST_IDX = (1 << FFT_STG) - 1;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_ready, w_ready_nxt;
  logic [TOTAL_STAGE-1:0] r_addr, w_addr_nxt;
  cplx_t                  r_data, w_data_nxt;
  logic                   r_en, w_en_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_acc;
  logic                   w_lat_load;
  logic                   w_lat_zero;

  assign w_acc = ivalid & r_ready;

  // Drain tracker, armed on the edge that accepts the last sample.
  fft_lat_cnt #(
    .LAT (PIPE_LAT)
  ) u_lat_cnt (
    .i_clk    (iclk),
    .i_rst    (irst),
    .i_load   (w_lat_load),
    .o_zero_c (w_lat_zero)
  );

  // State and output registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_lat_load  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (istart) begin
          w_state_nxt = ST_LOAD;
          w_ready_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (w_acc) begin
          w_en_nxt   = 1'b1;
          w_data_nxt = cplx_t'(idata);
          w_addr_nxt = TOTAL_STAGE'(r_cnt);
          if (r_cnt == CNT_W'(LAST_IDX)) begin
            w_state_nxt = ST_DRAIN;
            w_ready_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_lat_load  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`ifndef FFT_FRAME_STALL_EN
        // Non-zero count means the frame has started; a gap now is fatal.
        else if (!ivalid && (r_cnt != '0)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
`endif
      end
      ST_DRAIN: begin
        if (w_lat_zero) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_LOAD) | (w_state_nxt == ST_DRAIN);
  end

  assign oready = r_ready;
  assign oaddr  = r_addr;
  assign odata  = r_data;
  assign oen    = r_en;
  assign obusy  = r_busy;
  assign odone  = r_done;
  assign oerr   = r_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (FFT_STG=7, PIPE_LAT=14).
// Reference: the expected output stream of a frame is the list of samples the
// bench handed over, in order, addressed 0..N-1; odone follows the last oen by
// PIPE_LAT cycles. Gap handling follows the FFT_FRAME_STALL_EN build option.
module tb_fft_frame_ctrl;

  localparam int unsigned FFT_STG  = 7;
  localparam int unsigned N        = 128;
  localparam int unsigned PIPE_LAT = 14;
  localparam int unsigned TS       = 10;
  localparam int unsigned CW       = 32;

  logic          iclk = 1'b0;
  logic          irst, istart, ivalid;
  logic [CW-1:0] idata;
  logic          oready, oen, obusy, odone, oerr;
  logic [TS-1:0] oaddr;
  logic [CW-1:0] odata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int            q_addr[$];
  logic [CW-1:0] q_data[$];
  int            first_oen, last_oen, done_cnt, done_cyc;
  bit            hold_start;
  logic [CW-1:0] samp[N];

  fft_frame_ctrl #(
    .FFT_STG  (FFT_STG),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .iclk   (iclk),
    .irst   (irst),
    .istart (istart),
    .idata  (idata),
    .ivalid (ivalid),
    .oready (oready),
    .oaddr  (oaddr),
    .odata  (odata),
    .oen    (oen),
    .obusy  (obusy),
    .odone  (odone),
    .oerr   (oerr)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  // Output recorder.
  always @(negedge iclk) begin
    if (oen) begin
      if (q_addr.size() == 0) first_oen = cyc;
      q_addr.push_back(int'(oaddr));
      q_data.push_back(odata);
      last_oen = cyc;
    end
    if (odone) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clr();
    q_addr.delete();
    q_data.delete();
    done_cnt  = 0;
    first_oen = -1;
    last_oen  = -1;
    done_cyc  = -1;
  endtask

  task automatic new_samples();
    for (int i = 0; i < int'(N); i++) samp[i] = $urandom;
  endtask

  // Pulse istart, then offer samples until stop_at have been accepted.
  // gap_at/gap_len: drop ivalid for gap_len cycles once gap_at samples are in.
  task automatic drive_frame(input int gap_at, input int gap_len, input int stop_at,
                             input int pre_wait);
    int k, gap_left, pre_left, guard;
    bit rdy;
    istart = 1'b1;
    @(posedge iclk);
    #1 istart = hold_start;
    k = 0; gap_left = gap_len; pre_left = pre_wait; guard = 0;
    while (k < stop_at && guard < 3000) begin
      if (pre_left > 0) begin
        ivalid = 1'b0;
        pre_left--;
      end else if (k == gap_at && gap_left > 0) begin
        ivalid = 1'b0;
        gap_left--;
      end else begin
        ivalid = 1'b1;
        idata  = samp[k];
      end
      rdy = oready;
      @(posedge iclk);
      if (ivalid && rdy) k++;
      #1 guard++;
    end
    ivalid = 1'b0;
    chk("drive_in_time", 64'(guard < 3000), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
  endtask

  task automatic check_stream(input string tag, input int span);
    chk({tag, "_n_oen"}, 64'(q_addr.size()), 64'(N));
    for (int i = 0; i < q_addr.size() && i < int'(N); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(samp[i]));
    end
    chk({tag, "_oen_span"}, 64'(last_oen - first_oen), 64'(span));
    chk({tag, "_done_lat"}, 64'(done_cyc - last_oen), 64'(PIPE_LAT));
  endtask

  task automatic finish_frame(input string tag, input int span);
    wait_done(tag);
    repeat (4) @(negedge iclk);
    check_stream(tag, span);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    chk({tag, "_busy_after"}, 64'(obusy), 64'(0));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_oready"}, 64'(oready), 64'(0));
    chk({tag, "_oaddr"},  64'(oaddr),  64'(0));
    chk({tag, "_odata"},  64'(odata),  64'(0));
    chk({tag, "_oen"},    64'(oen),    64'(0));
    chk({tag, "_obusy"},  64'(obusy),  64'(0));
    chk({tag, "_odone"},  64'(odone),  64'(0));
    chk({tag, "_oerr"},   64'(oerr),   64'(0));
  endtask

  initial begin
    int d1, glen;
    irst = 1'b1; istart = 1'b0; ivalid = 1'b0; idata = '0; hold_start = 1'b0;
    mon_clr();
    repeat (3) @(posedge iclk);
    #1 chk_reset_outs("reset");
    irst = 1'b0;

    // Valid without istart in IDLE must not start anything.
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1;
      idata  = $urandom;
      @(posedge iclk);
      #1;
      chk("idle_oready", 64'(oready), 64'(0));
      chk("idle_oen",    64'(oen),    64'(0));
      chk("idle_obusy",  64'(obusy),  64'(0));
    end
    ivalid = 1'b0;

    // Contiguous frame with a legal wait before the first sample.
    new_samples(); mon_clr();
    drive_frame(-1, 0, N, int'($urandom_range(0, 5)));
    chk("f1_busy_drain", 64'(obusy), 64'(1));
    finish_frame("f1", N - 1);
    chk("f1_oerr", 64'(oerr), 64'(0));

    // istart held through two frames: ignored in LOAD/DRAIN/DONE, honoured in IDLE.
    hold_start = 1'b1;
    new_samples(); mon_clr();
    drive_frame(-1, 0, N, 0);
    wait_done("b2b1");
    check_stream("b2b1", N - 1);
    d1 = done_cyc;
    new_samples(); mon_clr();
    drive_frame(-1, 0, N, 0);
    istart = 1'b0; hold_start = 1'b0;
    finish_frame("b2b2", N - 1);
    chk("b2b2_restart", 64'(first_oen - d1), 64'(3));

`ifdef FFT_FRAME_STALL_EN
    // Gap of 10 cycles after sample 40, then a random gap elsewhere.
    new_samples(); mon_clr();
    drive_frame(40, 10, N, 0);
    finish_frame("gap40", N - 1 + 10);
    chk("gap40_oerr", 64'(oerr), 64'(0));
    glen = int'($urandom_range(1, 20));
    new_samples(); mon_clr();
    drive_frame(int'($urandom_range(1, N - 1)), glen, N, 0);
    finish_frame("gaprnd", N - 1 + glen);
    chk("gaprnd_oerr", 64'(oerr), 64'(0));
`else
    // Gap after sample 40 aborts the frame and latches oerr.
    glen = 0;
    new_samples(); mon_clr();
    drive_frame(-1, 0, 41, 0);
    @(posedge iclk);
    #1;
    chk("abort_oerr",   64'(oerr),   64'(1));
    chk("abort_oready", 64'(oready), 64'(0));
    chk("abort_obusy",  64'(obusy),  64'(0));
    chk("abort_oen",    64'(oen),    64'(0));
    repeat (40) @(negedge iclk);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_n_oen",   64'(q_addr.size()), 64'(41));
    new_samples(); mon_clr();
    drive_frame(-1, 0, N, 0);
    finish_frame("post_err", N - 1 + glen);
    chk("post_err_oerr", 64'(oerr), 64'(1));
`endif

    // Reset mid-frame at sample 60.
    new_samples(); mon_clr();
    drive_frame(-1, 0, 60, 0);
    irst = 1'b1;
    @(posedge iclk);
    #1 chk_reset_outs("midrst");
    irst = 1'b0;
    repeat (30) @(negedge iclk);
    chk("midrst_no_done", 64'(done_cnt), 64'(0));
    new_samples(); mon_clr();
    drive_frame(-1, 0, N, int'($urandom_range(0, 3)));
    finish_frame("fresh", N - 1);
    chk("fresh_oerr", 64'(oerr), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
